// File: rtl/alfa_note_display.sv
// Registered 7-segment decoder for a musical-note indicator.
// The glyph is the note letter (Tom=0) or the scale degree (Tom=1); a..g map to saida1..saida7.
module alfa_note_display (
  input  logic clk,
  input  logic rst,
  input  logic Tom,
  input  logic notas1,
  input  logic notas2,
  input  logic notas3,
  output logic saida1,
  output logic saida2,
  output logic saida3,
  output logic saida4,
  output logic saida5,
  output logic saida6,
  output logic saida7
);

  localparam logic [6:0] SegDash = 7'b0000001;

  logic [3:0] sel;
  logic [6:0] seg_d;
  logic [6:0] seg_q;

  assign sel = {Tom, notas1, notas2, notas3};

  // Plain case compares 4-state, so any X/Z select falls through to the dash default.
  always_comb begin
    seg_d = SegDash;
    case (sel)
      4'b0000: seg_d = 7'b1110111; // A
      4'b0001: seg_d = 7'b0011111; // b
      4'b0010: seg_d = 7'b1001110; // C
      4'b0011: seg_d = 7'b0111101; // d
      4'b0100: seg_d = 7'b1001111; // E
      4'b0101: seg_d = 7'b1000111; // F
      4'b0110: seg_d = 7'b1011110; // G
      4'b0111: seg_d = SegDash;
      4'b1000: seg_d = 7'b0110000; // 1
      4'b1001: seg_d = 7'b1101101; // 2
      4'b1010: seg_d = 7'b1111001; // 3
      4'b1011: seg_d = 7'b0110011; // 4
      4'b1100: seg_d = 7'b1011011; // 5
      4'b1101: seg_d = 7'b1011111; // 6
      4'b1110: seg_d = 7'b1110000; // 7
      4'b1111: seg_d = SegDash;
      default: seg_d = SegDash;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= 7'b0000000;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign saida1 = seg_q[6];
  assign saida2 = seg_q[5];
  assign saida3 = seg_q[4];
  assign saida4 = seg_q[3];
  assign saida5 = seg_q[2];
  assign saida6 = seg_q[1];
  assign saida7 = seg_q[0];

endmodule

// File: tb/tb_alfa_note_display.sv
// Bench for alfa_note_display: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a glyph-by-character reference model.
module tb_alfa_note_display;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic Tom = 1'b0;
  logic notas1 = 1'b0;
  logic notas2 = 1'b0;
  logic notas3 = 1'b0;
  logic saida1, saida2, saida3, saida4, saida5, saida6, saida7;

  int nvec = 0;
  int nerr = 0;

  alfa_note_display dut (
    .clk    (clk),
    .rst    (rst),
    .Tom    (Tom),
    .notas1 (notas1),
    .notas2 (notas2),
    .notas3 (notas3),
    .saida1 (saida1),
    .saida2 (saida2),
    .saida3 (saida3),
    .saida4 (saida4),
    .saida5 (saida5),
    .saida6 (saida6),
    .saida7 (saida7)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       tom;
    logic [2:0] n;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic t, logic [2:0] n, logic [6:0] e);
    vec_t v;
    v.rst = r;
    v.tom = t;
    v.n   = n;
    v.exp = e;
    return v;
  endfunction

  // Segment pattern (a..g) drawn for a displayed character.
  function automatic logic [6:0] seg_of(byte c);
    case (c)
      "A":     return 7'b1110111;
      "b":     return 7'b0011111;
      "C":     return 7'b1001110;
      "d":     return 7'b0111101;
      "E":     return 7'b1001111;
      "F":     return 7'b1000111;
      "G":     return 7'b1011110;
      "1":     return 7'b0110000;
      "2":     return 7'b1101101;
      "3":     return 7'b1111001;
      "4":     return 7'b0110011;
      "5":     return 7'b1011011;
      "6":     return 7'b1011111;
      "7":     return 7'b1110000;
      default: return 7'b0000001;
    endcase
  endfunction

  function automatic logic [6:0] model(logic r, logic t, logic [2:0] n);
    string letters;
    string digits;
    letters = "AbCdEFG-";
    digits  = "1234567-";
    if (r) return 7'b0000000;
    return seg_of(t ? digits[int'(n)] : letters[int'(n)]);
  endfunction

  function automatic logic [6:0] outs();
    return {saida1, saida2, saida3, saida4, saida5, saida6, saida7};
  endfunction

  task automatic check(string name, logic [6:0] exp);
    logic [6:0] got;
    got = outs();
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic apply(logic r, logic t, logic [2:0] n);
    @(negedge clk);
    rst = r;
    Tom = t;
    {notas1, notas2, notas3} = n;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] letter_tbl [8];
    logic [6:0] degree_tbl [8];
    letter_tbl = '{7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101,
                   7'b1001111, 7'b1000111, 7'b1011110, 7'b0000001};
    degree_tbl = '{7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                   7'b1011011, 7'b1011111, 7'b1110000, 7'b0000001};

    // Reset for two cycles with d on the inputs, then release.
    tbl.push_back(mk(1'b1, 1'b0, 3'd3, 7'b0000000));
    tbl.push_back(mk(1'b1, 1'b0, 3'd3, 7'b0000000));
    tbl.push_back(mk(1'b0, 1'b0, 3'd3, 7'b0111101));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1'b0, 1'b0, 3'(i), letter_tbl[i]));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1'b0, 1'b1, 3'(i), degree_tbl[i]));
    for (int i = 0; i < 6; i++) begin
      tbl.push_back(mk(1'b0, 1'(i % 2), 3'd4, (i % 2) ? 7'b1011011 : 7'b1001111));
    end

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].tom, tbl[i].n);
      check($sformatf("table[%0d]", i), tbl[i].exp);
    end

    // Reset while G is displayed: blank only after the next edge.
    apply(1'b0, 1'b0, 3'd6);
    check("g_before_rst", 7'b1011110);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_not_early", 7'b1011110);
    @(posedge clk);
    #1;
    check("rst_blank", 7'b0000000);
    apply(1'b0, 1'b1, 3'd1);
    check("rst_release", 7'b1101101);

    // Input changes with no clock edge between them are invisible.
    @(negedge clk);
    Tom = 1'b0;
    {notas1, notas2, notas3} = 3'd0;
    #1;
    check("no_edge_a", 7'b1101101);
    {notas1, notas2, notas3} = 3'd5;
    #1;
    Tom = 1'b1;
    #1;
    check("no_edge_b", 7'b1101101);
    @(posedge clk);
    #1;
    check("after_edge", 7'b1011111);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      logic       r;
      logic       t;
      logic [2:0] n;
      r = ($urandom_range(0, 15) == 0);
      t = 1'($urandom);
      n = 3'($urandom);
      apply(r, t, n);
      check($sformatf("rand[%0d] rst=%0d tom=%0d n=%0d", i, r, t, n), model(r, t, n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
